// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
//
// Iterative multiply/divide unit for the EX stage. Executes MULT, MULTU, DIV
// and DIVU one bit per cycle (radix-2 shift-add multiply, radix-2 restoring
// divide) and owns the architectural HI/LO registers, which MTHI/MTLO can also
// write while the unit is idle.
//
// Optional feature (compile-time macro MD_EARLY_OUT_EN):
//   When defined, a start whose operands include a zero skips the iterative
//   datapath. Multiply-by-zero and zero-dividend give HI=LO=0, and
//   divide-by-zero gives the same values as the full algorithm. Such an op
//   holds Md_busy for 1 cycle. When the macro is undefined, every operation
//   takes the full 34 cycles and no zero-detect logic is built.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous active-high reset
//   Md_start   in   1   start request, only sampled in IDLE
//   Md_op      in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   Md_a       in  32   rs operand (multiplicand / dividend)
//   Md_b       in  32   rt operand (multiplier / divisor)
//   Hi_we      in   1   MTHI write enable
//   Lo_we      in   1   MTLO write enable
//   Md_wdata   in  32   MTHI/MTLO data
//   Md_busy    out  1   high while an operation is in flight
//   Md_done    out  1   one-cycle pulse after HI/LO take a new result
//   Hi_out     out 32   HI register
//   Lo_out     out 32   LO register
//   dbg_state  out  2   current FSM state, for observation only
//
// Handshake: a start is accepted on a rising edge where Md_start=1 and
// Md_busy=0. Md_busy then stays high until the result is written, and Md_done
// is high for exactly the one cycle after that write. Starts and MTHI/MTLO
// writes seen while Md_busy=1 are dropped, not queued. An accepted start
// takes priority over an MTHI/MTLO write in the same cycle.
//
// Timing for a start accepted at edge E0: PREP in the cycle after E0, CALC for
// the 32 cycles after E1..E32, SIGN in the cycle after E33. HI/LO are written
// at E34, so Md_busy is high for 34 cycles.
// -----------------------------------------------------------------------------
module mul_div_unit #(
    parameter int ITERS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Md_start,
    input  logic [1:0]  Md_op,
    input  logic [31:0] Md_a,
    input  logic [31:0] Md_b,
    input  logic        Hi_we,
    input  logic        Lo_we,
    input  logic [31:0] Md_wdata,
    output logic        Md_busy,
    output logic        Md_done,
    output logic [31:0] Hi_out,
    output logic [31:0] Lo_out,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PREP = 2'd1;
    localparam logic [1:0] S_CALC = 2'd2;
    localparam logic [1:0] S_SIGN = 2'd3;

    localparam int CW = $clog2(ITERS);
    localparam logic [CW-1:0] LAST_CNT = CW'(ITERS - 1);

    logic [1:0]    state;
    logic [1:0]    op_q;
    logic          sign_a;
    logic          sign_b;
    logic [31:0]   a_q;
    logic [31:0]   b_q;
    logic [31:0]   mag_a;
    logic [31:0]   mag_b;
    // Multiply: 64-bit product with the multiplier initially in the low half.
    // Divide: {remainder, quotient} with the dividend initially in the low half.
    logic [63:0]   acc;
    logic [CW-1:0] cnt;
    logic [31:0]   hi_q;
    logic [31:0]   lo_q;
    logic          done_q;
`ifdef MD_EARLY_OUT_EN
    logic          early_q;
    logic          early_hit;
`endif

    logic          is_div_q;
    logic [31:0]   abs_a;
    logic [31:0]   abs_b;
    logic [32:0]   mul_sum;
    logic [63:0]   mul_next;
    logic [32:0]   div_rem;
    logic          div_ge;
    logic [31:0]   div_sub;
    logic [63:0]   div_next;
    logic [63:0]   prod_neg;
    logic [31:0]   quot_neg;
    logic [31:0]   rem_neg;
    logic [31:0]   res_hi;
    logic [31:0]   res_lo;

    assign is_div_q = op_q[1];

    // Magnitudes of the latched raw operands. The sign flags are already
    // zero for unsigned ops, so those pass through unchanged. 0x80000000
    // negates to itself, which is the correct unsigned magnitude.
    assign abs_a = sign_a ? (~a_q + 32'd1) : a_q;
    assign abs_b = sign_b ? (~b_q + 32'd1) : b_q;

    // One shift-add step. The 33-bit sum keeps the carry out of the upper
    // half so the right shift brings it back in as the new MSB.
    assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_a} : 33'd0);
    assign mul_next = {mul_sum, acc[31:1]};

    // One restoring step. After the left shift the partial remainder is 33
    // bits wide. When it is >= divisor, the difference fits in 32 bits, so
    // only the low 32 bits of the subtraction are kept.
    assign div_rem  = acc[63:31];
    assign div_ge   = (div_rem >= {1'b0, mag_b});
    assign div_sub  = div_rem[31:0] - mag_b;
    assign div_next = {(div_ge ? div_sub : div_rem[31:0]), acc[30:0], div_ge};

    assign prod_neg = ~acc + 64'd1;
    assign quot_neg = ~acc[31:0] + 32'd1;
    assign rem_neg  = ~acc[63:32] + 32'd1;

`ifdef MD_EARLY_OUT_EN
    assign early_hit = (Md_a == 32'd0) || (Md_b == 32'd0);
`endif

    // Final sign correction, applied in SIGN and written to HI/LO on the
    // SIGN->IDLE edge. The quotient takes the sign of a^b. The remainder takes
    // the sign of the dividend.
    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        if (!is_div_q) begin
            if (sign_a ^ sign_b) begin
                res_hi = prod_neg[63:32];
                res_lo = prod_neg[31:0];
            end else begin
                res_hi = acc[63:32];
                res_lo = acc[31:0];
            end
        end else begin
            res_lo = (sign_a ^ sign_b) ? quot_neg : acc[31:0];
            res_hi = sign_a ? rem_neg : acc[63:32];
        end
`ifdef MD_EARLY_OUT_EN
        // The iterative datapath did not run, so force the results. Divide by
        // zero reproduces what the restoring algorithm would have produced.
        if (early_q) begin
            if (is_div_q && (b_q == 32'd0)) begin
                res_hi = a_q;
                res_lo = sign_a ? 32'h0000_0001 : 32'hFFFF_FFFF;
            end else begin
                res_hi = 32'd0;
                res_lo = 32'd0;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            op_q    <= 2'd0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            mag_a   <= 32'd0;
            mag_b   <= 32'd0;
            acc     <= 64'd0;
            cnt     <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
`ifdef MD_EARLY_OUT_EN
            early_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Md_start) begin
                        // Operands are captured raw here. The magnitude
                        // negation happens in PREP, which keeps it off the
                        // start path.
                        op_q   <= Md_op;
                        a_q    <= Md_a;
                        b_q    <= Md_b;
                        sign_a <= ~Md_op[0] & Md_a[31];
                        sign_b <= ~Md_op[0] & Md_b[31];
                        cnt    <= '0;
`ifdef MD_EARLY_OUT_EN
                        early_q <= early_hit;
                        state   <= early_hit ? S_SIGN : S_PREP;
`else
                        state  <= S_PREP;
`endif
                    end else begin
                        if (Hi_we) hi_q <= Md_wdata;
                        if (Lo_we) lo_q <= Md_wdata;
                    end
                end

                S_PREP: begin
                    mag_a <= abs_a;
                    mag_b <= abs_b;
                    acc   <= is_div_q ? {32'd0, abs_a} : {32'd0, abs_b};
                    cnt   <= '0;
                    state <= S_CALC;
                end

                S_CALC: begin
                    acc <= is_div_q ? div_next : mul_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        state <= S_SIGN;
                    end
                end

                S_SIGN: begin
                    hi_q   <= res_hi;
                    lo_q   <= res_lo;
                    done_q <= 1'b1;
                    state  <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    assign Md_busy   = (state != S_IDLE);
    assign Md_done   = done_q;
    assign Hi_out    = hi_q;
    assign Lo_out    = lo_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_mul_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit
//
// Self-checking bench for mul_div_unit. Expected HI/LO values come from a
// reference function that applies the architectural rules with 64-bit
// arithmetic. Each scenario task does its own comparisons. Define
// MD_EARLY_OUT_EN for both bench and RTL to exercise the zero-operand
// shortcut.
// -----------------------------------------------------------------------------
module tb_mul_div_unit;

    logic        clk;
    logic        rst;
    logic        Md_start;
    logic [1:0]  Md_op;
    logic [31:0] Md_a;
    logic [31:0] Md_b;
    logic        Hi_we;
    logic        Lo_we;
    logic [31:0] Md_wdata;
    logic        Md_busy;
    logic        Md_done;
    logic [31:0] Hi_out;
    logic [31:0] Lo_out;
    logic [1:0]  dbg_state;

    int checks;
    int passed;

    logic [63:0] exp_q[$];

`ifdef MD_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    mul_div_unit #(.ITERS(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .Md_start  (Md_start),
        .Md_op     (Md_op),
        .Md_a      (Md_a),
        .Md_b      (Md_b),
        .Hi_we     (Hi_we),
        .Lo_we     (Lo_we),
        .Md_wdata  (Md_wdata),
        .Md_busy   (Md_busy),
        .Md_done   (Md_done),
        .Hi_out    (Hi_out),
        .Lo_out    (Lo_out),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // ---------------- reference model ----------------
    // Returns {HI, LO} using plain 64-bit arithmetic and the architectural
    // divide-by-zero rules.
    function automatic logic [63:0] model(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        p = 64'd0;
        case (op)
            OP_MULT: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = sa * sb;
            end
            OP_MULTU: p = {32'd0, a} * {32'd0, b};
            OP_DIV: begin
                if (b == 32'd0) begin
                    p = {a, (a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
                end else begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    q  = sa / sb;
                    r  = sa % sb;
                    p  = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else            p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    function automatic int exp_latency(input logic [1:0] op,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
        if (EARLY && ((a == 32'd0) || (b == 32'd0))) return 1;
        return 34;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 20));
            4:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- driver + checks for one operation ----------------
    task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input string name);
        int cycles;
        int busy_cnt;
        int lat;
        logic [63:0] exp;
        exp_q.push_back(model(op, a, b));
        lat = exp_latency(op, a, b);
        Md_op    = op;
        Md_a     = a;
        Md_b     = b;
        Md_start = 1'b1;
        step();
        Md_start = 1'b0;
        Hi_we    = 1'b0;
        Lo_we    = 1'b0;
        // Operands need not be held after the start edge.
        Md_a     = $urandom;
        Md_b     = $urandom;
        Md_op    = 2'($urandom_range(0, 3));
        cycles   = 0;
        busy_cnt = 0;
        while (!Md_done && cycles < 100) begin
            if (Md_busy) busy_cnt++;
            step();
            cycles++;
        end
        exp = exp_q.pop_front();
        checks++;
        if (cycles !== lat)
            $display("FAIL %s latency: got %0d cycles, want %0d", name, cycles, lat);
        else passed++;
        checks++;
        if (busy_cnt !== lat)
            $display("FAIL %s busy_cycles: got %0d, want %0d", name, busy_cnt, lat);
        else passed++;
        checks++;
        if (Hi_out !== exp[63:32])
            $display("FAIL %s hi: got %h, want %h", name, Hi_out, exp[63:32]);
        else passed++;
        checks++;
        if (Lo_out !== exp[31:0])
            $display("FAIL %s lo: got %h, want %h", name, Lo_out, exp[31:0]);
        else passed++;
        checks++;
        if (Md_busy !== 1'b0)
            $display("FAIL %s busy_at_done: got %b, want 0", name, Md_busy);
        else passed++;
        step();
        checks++;
        if (Md_done !== 1'b0)
            $display("FAIL %s done_width: got %b one cycle later, want 0", name, Md_done);
        else passed++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        Md_start = 1'b1;
        Md_op    = OP_MULTU;
        Md_a     = $urandom;
        Md_b     = $urandom;
        Hi_we    = 1'b1;
        Lo_we    = 1'b1;
        Md_wdata = 32'hDEAD_BEEF;
        apply_reset();
        Md_start = 1'b0;
        Hi_we    = 1'b0;
        Lo_we    = 1'b0;
        checks++;
        if (Md_busy !== 1'b0) $display("FAIL reset_busy: got %b, want 0", Md_busy);
        else passed++;
        checks++;
        if (Md_done !== 1'b0) $display("FAIL reset_done: got %b, want 0", Md_done);
        else passed++;
        checks++;
        if (Hi_out !== 32'd0) $display("FAIL reset_hi: got %h, want 0", Hi_out);
        else passed++;
        checks++;
        if (Lo_out !== 32'd0) $display("FAIL reset_lo: got %h, want 0", Lo_out);
        else passed++;
    endtask

    task automatic test_directed();
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        run_op(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, "mult_neg3x7");
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, "div_neg7by2");
        run_op(OP_DIVU,  32'd100,       32'd7,         "divu_100by7");
        run_op(OP_DIVU,  32'd5,         32'd0,         "divu_by0");
        run_op(OP_DIV,   32'hFFFF_FFF6, 32'd0,         "div_neg_by0");
        run_op(OP_DIV,   32'd9,         32'd0,         "div_pos_by0");
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_min_by_m1");
        run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, "mult_min_sq");
        run_op(OP_MULT,  32'd0,         32'h1234_5678, "mult_zero");
        run_op(OP_DIV,   32'd0,         32'hFFFF_FFF0, "div_zero_dividend");
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            run_op(2'($urandom_range(0, 3)), rand_operand(), rand_operand(), "random");
        end
    endtask

    task automatic test_mthi_mtlo();
        Hi_we = 1'b1; Lo_we = 1'b0; Md_wdata = 32'h1111_2222;
        step();
        Hi_we = 1'b0; Lo_we = 1'b1; Md_wdata = 32'h3333_4444;
        step();
        Lo_we = 1'b0;
        checks++;
        if (Hi_out !== 32'h1111_2222) $display("FAIL mthi: got %h, want 11112222", Hi_out);
        else passed++;
        checks++;
        if (Lo_out !== 32'h3333_4444) $display("FAIL mtlo: got %h, want 33334444", Lo_out);
        else passed++;
        Hi_we = 1'b1; Lo_we = 1'b1; Md_wdata = 32'h5A5A_0F0F;
        step();
        Hi_we = 1'b0; Lo_we = 1'b0;
        checks++;
        if (Hi_out !== 32'h5A5A_0F0F || Lo_out !== 32'h5A5A_0F0F)
            $display("FAIL mt_both: got hi %h lo %h, want 5a5a0f0f both", Hi_out, Lo_out);
        else passed++;
        repeat (3) step();
        checks++;
        if (Hi_out !== 32'h5A5A_0F0F || Lo_out !== 32'h5A5A_0F0F)
            $display("FAIL hold: got hi %h lo %h, want 5a5a0f0f both", Hi_out, Lo_out);
        else passed++;
        // A write in the same cycle as an accepted start is dropped.
        Hi_we = 1'b1; Lo_we = 1'b1; Md_wdata = 32'hDEAD_DEAD;
        run_op(OP_DIVU, 32'd9, 32'd3, "start_beats_mt");
    endtask

    task automatic test_ignore_while_busy();
        int cycles;
        Md_op = OP_DIVU; Md_a = 32'd100; Md_b = 32'd7; Md_start = 1'b1;
        step();
        Md_start = 1'b0;
        Md_op = OP_MULTU; Md_a = 32'd3; Md_b = 32'd3; Md_wdata = 32'h0000_1234;
        cycles = 0;
        while (!Md_done && cycles < 100) begin
            Md_start = (cycles == 5);
            Hi_we    = (cycles == 10);
            step();
            cycles++;
        end
        Md_start = 1'b0;
        Hi_we    = 1'b0;
        checks++;
        if (cycles !== 34) $display("FAIL busy_ignore_latency: got %0d, want 34", cycles);
        else passed++;
        checks++;
        if (Hi_out !== 32'd2 || Lo_out !== 32'd14)
            $display("FAIL busy_ignore_result: got hi %h lo %h, want 2 / e", Hi_out, Lo_out);
        else passed++;
        Lo_we = 1'b1; Md_wdata = 32'h0000_ABCD;
        step();
        Lo_we = 1'b0;
        checks++;
        if (Lo_out !== 32'h0000_ABCD || Hi_out !== 32'd2)
            $display("FAIL mtlo_after_done: got hi %h lo %h, want 2 / abcd", Hi_out, Lo_out);
        else passed++;
        checks++;
        if (Md_busy !== 1'b0) $display("FAIL no_queued_start: busy %b, want 0", Md_busy);
        else passed++;
    endtask

    task automatic test_abort();
        int done_seen;
        Md_op = OP_MULTU; Md_a = 32'hFFFF_FFFF; Md_b = 32'd2; Md_start = 1'b1;
        step();
        Md_start = 1'b0;
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (Md_busy !== 1'b0 || Hi_out !== 32'd0 || Lo_out !== 32'd0)
            $display("FAIL abort_state: got busy %b hi %h lo %h, want 0/0/0",
                     Md_busy, Hi_out, Lo_out);
        else passed++;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (Md_done) done_seen++;
            step();
        end
        checks++;
        if (done_seen !== 0) $display("FAIL abort_no_done: got %0d pulses, want 0", done_seen);
        else passed++;
        run_op(OP_MULTU, 32'd6, 32'd7, "after_abort");
    endtask

    // ---------------- main ----------------
    initial begin
        checks   = 0;
        passed   = 0;
        rst      = 1'b0;
        Md_start = 1'b0;
        Md_op    = 2'd0;
        Md_a     = 32'd0;
        Md_b     = 32'd0;
        Hi_we    = 1'b0;
        Lo_we    = 1'b0;
        Md_wdata = 32'd0;
        test_reset();
        test_directed();
        test_mthi_mtlo();
        test_ignore_while_busy();
        test_abort();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
